// File: rtl/hdmi_vram_axil_slave_if.sv
// AXI4-Lite channel bundle between the CPU-side master and the VRAM slave.
interface hdmi_vram_axil_slave_if #(
  parameter int unsigned ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] axi_awaddr;
  logic [2:0]            axi_awprot;
  logic                  axi_awvalid;
  logic                  axi_awready;
  logic [31:0]           axi_wdata;
  logic [3:0]            axi_wstrb;
  logic                  axi_wvalid;
  logic                  axi_wready;
  logic [1:0]            axi_bresp;
  logic                  axi_bvalid;
  logic                  axi_bready;
  logic [ADDR_WIDTH-1:0] axi_araddr;
  logic [2:0]            axi_arprot;
  logic                  axi_arvalid;
  logic                  axi_arready;
  logic [31:0]           axi_rdata;
  logic [1:0]            axi_rresp;
  logic                  axi_rvalid;
  logic                  axi_rready;

  modport master (
    output axi_awaddr, axi_awprot, axi_awvalid,
    input  axi_awready,
    output axi_wdata, axi_wstrb, axi_wvalid,
    input  axi_wready,
    input  axi_bresp, axi_bvalid,
    output axi_bready,
    output axi_araddr, axi_arprot, axi_arvalid,
    input  axi_arready,
    input  axi_rdata, axi_rresp, axi_rvalid,
    output axi_rready
  );

  modport slave (
    input  axi_awaddr, axi_awprot, axi_awvalid,
    output axi_awready,
    input  axi_wdata, axi_wstrb, axi_wvalid,
    output axi_wready,
    output axi_bresp, axi_bvalid,
    input  axi_bready,
    input  axi_araddr, axi_arprot, axi_arvalid,
    output axi_arready,
    output axi_rdata, axi_rresp, axi_rvalid,
    input  axi_rready
  );
endinterface

// File: rtl/hdmi_vram_axil_slave.sv
// Text-mode VRAM + control words behind an AXI4-Lite slave, with a free-running
// read-only video fetch port for the glyph pipeline. Data bus is fixed at 32 bits.
module hdmi_vram_axil_slave #(
  parameter int unsigned C_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_AXI_ADDR_WIDTH = 16,
  parameter int unsigned VRAM_WORDS       = 600,
  parameter int unsigned CTRL_WORDS       = 1,
  parameter int unsigned VID_ADDR_WIDTH   = 10
) (
  input  logic                        axi_aclk,
  input  logic                        axi_aresetn,
  hdmi_vram_axil_slave_if.slave       axi,
  input  logic [VID_ADDR_WIDTH-1:0]   vid_addr,
  output logic [31:0]                 vid_rdata,
  output logic [32*CTRL_WORDS-1:0]    ctrl_regs
);

  localparam int unsigned IDX_W       = C_AXI_ADDR_WIDTH - 2;
  localparam int unsigned TOTAL_WORDS = VRAM_WORDS + CTRL_WORDS;
  localparam int unsigned MEM_AW      = (TOTAL_WORDS > 1) ? $clog2(TOTAL_WORDS) : 1;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  // Combinational view of every stored word (VRAM then control words).
  logic [31:0] mem [TOTAL_WORDS];

  logic              ready_en;
  logic              aw_held;
  logic              w_held;
  logic              bvalid_q;
  logic [1:0]        bresp_q;
  logic [IDX_W-1:0]  aw_idx_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic              rvalid_q;
  logic [31:0]       rdata_q;
  logic [1:0]        rresp_q;

  logic              aw_hs_c;
  logic              w_hs_c;
  logic              ar_hs_c;
  logic              commit_c;
  logic              wr_in_range_c;
  logic              rd_in_range_c;
  logic              vid_in_range_c;
  logic [IDX_W-1:0]  ar_idx_c;
  logic [MEM_AW-1:0] wr_mem_idx_c;
  logic [MEM_AW-1:0] rd_mem_idx_c;
  logic [MEM_AW-1:0] vid_mem_idx_c;
  logic [31:0]       strb_mask_c;
  logic [31:0]       merged_c;

  // Protection bits and the byte offset inside a word carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{axi.axi_awprot, axi.axi_arprot,
                         axi.axi_awaddr[1:0], axi.axi_araddr[1:0]};

  // Handshake decode and address classification.
  always_comb begin
    aw_hs_c        = axi.axi_awvalid && axi.axi_awready;
    w_hs_c         = axi.axi_wvalid && axi.axi_wready;
    ar_hs_c        = axi.axi_arvalid && axi.axi_arready;
    commit_c       = aw_held && w_held;
    ar_idx_c       = axi.axi_araddr[C_AXI_ADDR_WIDTH-1:2];
    wr_in_range_c  = 32'(aw_idx_q) < TOTAL_WORDS;
    rd_in_range_c  = 32'(ar_idx_c) < TOTAL_WORDS;
    vid_in_range_c = 32'(vid_addr) < VRAM_WORDS;
    wr_mem_idx_c   = MEM_AW'(aw_idx_q);
    rd_mem_idx_c   = MEM_AW'(ar_idx_c);
    vid_mem_idx_c  = MEM_AW'(vid_addr);
    strb_mask_c    = {{8{wstrb_q[3]}}, {8{wstrb_q[2]}}, {8{wstrb_q[1]}}, {8{wstrb_q[0]}}};
    merged_c       = (mem[wr_mem_idx_c] & ~strb_mask_c) | (wdata_q & strb_mask_c);
  end

  // Ready lines stay low while reset is held and open on the first edge after.
  assign axi.axi_awready = ready_en && !aw_held && !bvalid_q;
  assign axi.axi_wready  = ready_en && !w_held && !bvalid_q;
  assign axi.axi_arready = ready_en && !rvalid_q;
  assign axi.axi_bvalid  = bvalid_q;
  assign axi.axi_bresp   = bresp_q;
  assign axi.axi_rvalid  = rvalid_q;
  assign axi.axi_rdata   = rdata_q;
  assign axi.axi_rresp   = rresp_q;

  // Out-of-reset flag that gates the ready lines.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) ready_en <= 1'b0;
    else              ready_en <= 1'b1;
  end

  // Write channel: capture AW and W independently, commit once both are held.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      aw_idx_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      if (bvalid_q && axi.axi_bready) bvalid_q <= 1'b0;
      if (aw_hs_c) begin
        aw_held  <= 1'b1;
        aw_idx_q <= axi.axi_awaddr[C_AXI_ADDR_WIDTH-1:2];
      end
      if (w_hs_c) begin
        w_held  <= 1'b1;
        wdata_q <= axi.axi_wdata;
        wstrb_q <= axi.axi_wstrb;
      end
      if (commit_c) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q  <= wr_in_range_c ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  // One register per word so each clears on reset and takes byte-merged commits.
  for (genvar g = 0; g < TOTAL_WORDS; g++) begin : g_word
    logic [31:0] word_q;

    // Word storage update on an in-range commit to this index.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn)
        word_q <= '0;
      else if (commit_c && wr_in_range_c && (wr_mem_idx_c == MEM_AW'(g)))
        word_q <= merged_c;
    end

    assign mem[g] = word_q;
  end

  // Read channel: load data on the AR edge (pre-commit value on a collision).
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_hs_c) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_in_range_c ? mem[rd_mem_idx_c] : 32'h0;
      rresp_q  <= rd_in_range_c ? RESP_OKAY : RESP_SLVERR;
    end else if (rvalid_q && axi.axi_rready) begin
      rvalid_q <= 1'b0;
    end
  end

  // Video fetch: registered lookup every cycle, independent of the AXI side.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn)       vid_rdata <= '0;
    else if (vid_in_range_c) vid_rdata <= mem[vid_mem_idx_c];
    else                     vid_rdata <= '0;
  end

  // Flat control-word view, word 0 in the LSBs.
  for (genvar c = 0; c < CTRL_WORDS; c++) begin : g_ctrl
    assign ctrl_regs[32*c +: 32] = mem[MEM_AW'(VRAM_WORDS + c)];
  end

endmodule

// File: doc/hdmi_vram_axil_slave.md
# hdmi_vram_axil_slave

Parametrised AXI4-Lite slave that holds the text-mode VRAM and control registers of the HDMI text controller and serves a second, read-only video fetch port to the pixel/glyph pipeline. It generalises the fixed 600-word, full-word-write register file:
- word count, control-register count and address width are configurable;
- byte-strobe writes are honoured;
- AW and W are accepted independently;
- out-of-range accesses return SLVERR.

## Interface
Parameters:
- C_AXI_DATA_WIDTH, 32, bus data width; only 32 is supported, which gives 4 byte lanes.
- C_AXI_ADDR_WIDTH, 16, byte-address width.
- VRAM_WORDS, 600, number of VRAM words, at word indices 0..VRAM_WORDS-1.
- CTRL_WORDS, 1, number of control words, at word indices VRAM_WORDS..VRAM_WORDS+CTRL_WORDS-1.
- VID_ADDR_WIDTH, 10, width of the video-port word index.

Ports:
- axi_aclk  in  1  sole clock.
- axi_aresetn  in  1  asynchronous active-low reset.
- axi_awaddr  in  C_AXI_ADDR_WIDTH  write byte address.
- axi_awprot  in  3  ignored.
- axi_awvalid  in  1; axi_awready  out  1.
- axi_wdata  in  32; axi_wstrb  in  4; axi_wvalid  in  1; axi_wready  out  1.
- axi_bresp  out  2; axi_bvalid  out  1; axi_bready  in  1.
- axi_araddr  in  C_AXI_ADDR_WIDTH; axi_arprot  in  3  ignored.
- axi_arvalid  in  1; axi_arready  out  1.
- axi_rdata  out  32; axi_rresp  out  2; axi_rvalid  out  1; axi_rready  in  1.
- vid_addr  in  VID_ADDR_WIDTH  video fetch word index.
- vid_rdata  out  32  registered VRAM word.
- ctrl_regs  out  32*CTRL_WORDS  flat view of the control words; word 0 is in the LSBs.

## Operation
Addressing:
- Word index = addr[C_AXI_ADDR_WIDTH-1:2]; addr[1:0] is ignored.
- An index is in range if it is < VRAM_WORDS+CTRL_WORDS.

Write path. Three flags: aw_held, w_held, bvalid.
- axi_awready = !aw_held && !axi_bvalid.
- axi_wready = !w_held && !axi_bvalid.
- An AW handshake latches the address and sets aw_held. A W handshake latches data and strobe and sets w_held. The two may occur in the same cycle or in either order, with any gap between them.
- Commit happens on the first edge at which aw_held && w_held:
  - in range: each byte lane i with wstrb[i]=1 is written, other lanes are preserved, and bresp=00 (OKAY);
  - out of range: no write, bresp=10 (SLVERR);
  - in both cases both held flags clear and bvalid is set.
- bvalid holds until the edge where axi_bready=1, then clears.
- wstrb=0 in range: no byte changes, OKAY response.

Read path:
- axi_arready = !axi_rvalid.
- On an AR handshake, rdata and rresp are loaded on the same edge and rvalid is set:
  - in range: the stored word, rresp=00;
  - out of range: 0, rresp=10.
- rdata/rresp/rvalid hold stable until the edge with axi_rready=1, then rvalid clears.
- Read/write collision: if an AR handshake and a write commit to the same index fall on the same edge, rdata returns the pre-write value.

Video port:
- vid_rdata <= word[vid_addr] each edge if vid_addr < VRAM_WORDS, else 0.
- The video port never stalls the AXI side or is stalled by it.
- A write committing on edge N is visible on vid_rdata from edge N+1 onward.

ctrl_regs:
- Driven combinationally from the control-word storage.
- Updates on the commit edge.

## Timing
- Reset (asynchronous assert, synchronous to the edge on release):
  - all storage is 0;
  - axi_awready, axi_wready and axi_arready are 0 while reset is asserted and go to 1 on the first edge after release;
  - axi_bvalid, axi_rvalid, axi_bresp, axi_rresp, axi_rdata, vid_rdata and ctrl_regs are all 0.
- Write, AW and W in the same cycle:
  - handshake at edge N, commit and bvalid=1 at edge N+1;
  - awready and wready are 0 from N+1 until bvalid clears;
  - minimum 3 cycles per write with bready held at 1.
- Write, AW before W: awready drops after the AW handshake, wready stays 1, and commit happens 1 edge after the W handshake.
- Read: AR handshake at edge N; rvalid=1 with data after edge N. With rready=1 the next handshake is possible at N+2.
- Reset asserted mid-transaction: held flags, bvalid and rvalid clear immediately and the pending write is dropped. Storage also returns to 0.
- A valid input dropped before its handshake is a master protocol violation. Behaviour is unspecified but must not hang: the flags still follow the rules above.

## Test plan
- Reset: hold axi_aresetn=0 for 4 cycles and release → the ready signals rise on the first edge; every read of index 0..600 returns 0 with OKAY.
- Full-word fill: write i to byte address 4*i for i=0..599, then write 0x001F6000 to 2400; read back all 601 words → exact match and OKAY; ctrl_regs=0x001F6000.
- Byte strobes: write 0xAABBCCDD to address 8, then write 0x11223344 with wstrb=0101 → readback 0xAA22CC44; with wstrb=0000 the value is unchanged.
- Independent channels: present AW 5 cycles before W, then W 5 cycles before AW, with bready delayed 3 cycles → single commit, each response OKAY, and awready/wready sequencing as specified.
- Errors: write and read at byte address 2404 (index 601) → SLVERR, rdata=0, no storage change; vid_addr=700 → vid_rdata=0.
- Collision: same-edge AR handshake and write commit to index 10 (old 0x5, new 0x9) → rdata=0x5, a subsequent read returns 0x9, and vid_addr=10 shows 0x9 one edge after the commit.
